odometer_meas_ctrl: RTL and testbench

// - Measurement side of the odometer ring oscillators: drives the ROSC enable (IN) of one

---
 rtl/odometer_meas_ctrl_pkg.sv | 17 +
 rtl/odometer_meas_ctrl_if.sv | 28 ++
 rtl/odometer_meas_ctrl_edge_sync.sv | 26 ++
 rtl/odometer_meas_ctrl.sv | 134 +++++++++++++
 tb/tb_odometer_meas_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/odometer_meas_ctrl_pkg.sv
// Shared types and default sizes for the odometer measurement controller.
package odometer_meas_ctrl_pkg;

    // Measurement sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COUNT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_WIN_W       = 16;
    localparam int DEF_SETTLE_CYC  = 8;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/odometer_meas_ctrl_if.sv
// Core-side bus of the odometer measurement controller, plus the two
// divided oscillator returns and the oscillator enable.
interface odometer_meas_ctrl_if #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
);
    logic                    START;
    logic [WIN_W-1:0]        WIN_LEN;
    logic                    OSC_REF_IN;
    logic                    OSC_STR_IN;
    logic                    ROSC_EN;
    logic                    BUSY;
    logic                    DONE;
    logic [CNT_W-1:0]        CNT_REF;
    logic [CNT_W-1:0]        CNT_STR;
    logic signed [CNT_W:0]   DIFF;
    logic                    OVF;

    modport master (
        output START, WIN_LEN, OSC_REF_IN, OSC_STR_IN,
        input  ROSC_EN, BUSY, DONE, CNT_REF, CNT_STR, DIFF, OVF
    );

    modport slave (
        input  START, WIN_LEN, OSC_REF_IN, OSC_STR_IN,
        output ROSC_EN, BUSY, DONE, CNT_REF, CNT_STR, DIFF, OVF
    );
endinterface

// File: rtl/odometer_meas_ctrl_edge_sync.sv
// Multi-flop synchronizer for an asynchronous oscillator return, followed by
// a single-cycle rising-edge pulse in the CLK domain.
module odometer_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;

    // Shift the async level through the synchronizer, keep one delayed copy
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_sync_d;
endmodule

// File: rtl/odometer_meas_ctrl.sv
// Odometer measurement controller: enables the reference and stressed ring
// oscillators, counts their edges over a programmable window and reports
// both counts plus their signed difference (the aging metric).
module odometer_meas_ctrl
    import odometer_meas_ctrl_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int WIN_W       = DEF_WIN_W,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                 CLK,
    input  logic                 RST,
    odometer_meas_ctrl_if.slave  bus
);
    localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYC - 1);

    state_t                r_state;
    logic [WIN_W-1:0]      r_win;
    logic [WIN_W-1:0]      r_tmr;
    logic [CNT_W-1:0]      r_cnt_ref;
    logic [CNT_W-1:0]      r_cnt_str;
    logic                  r_rosc_en;
    logic                  r_busy;
    logic                  r_done;
    logic [CNT_W-1:0]      r_res_ref;
    logic [CNT_W-1:0]      r_res_str;
    logic signed [CNT_W:0] r_res_diff;
    logic                  r_res_ovf;
    logic                  w_rise_ref;
    logic                  w_rise_str;
    logic signed [CNT_W:0] w_diff;

    // Saturating increment: a full counter stays at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic rise);
        if (rise && (c != '1))
            return c + 1'b1;
        return c;
    endfunction

    odometer_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ref (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_async (bus.OSC_REF_IN),
        .o_rise  (w_rise_ref)
    );

    odometer_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_str (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_async (bus.OSC_STR_IN),
        .o_rise  (w_rise_str)
    );

    // Difference of the saturated counts, both zero-extended before subtracting
    assign w_diff = $signed({1'b0, r_cnt_ref}) - $signed({1'b0, r_cnt_str});

    // Measurement sequencer with registered outputs and edge counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_win      <= '0;
            r_tmr      <= '0;
            r_cnt_ref  <= '0;
            r_cnt_str  <= '0;
            r_rosc_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_res_ref  <= '0;
            r_res_str  <= '0;
            r_res_diff <= '0;
            r_res_ovf  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    if (bus.START) begin
                        r_busy    <= 1'b1;
                        r_cnt_ref <= '0;
                        r_cnt_str <= '0;
                        if (bus.WIN_LEN != '0) begin
                            r_win     <= bus.WIN_LEN;
                            r_tmr     <= SETTLE_LAST;
                            r_rosc_en <= 1'b1;
                            r_state   <= SETTLE;
                        end else begin
                            // Empty window: report zeros without enabling the oscillators
                            r_state <= DONE;
                        end
                    end
                end
                SETTLE: begin
                    if (r_tmr == '0) begin
                        r_tmr     <= r_win - 1'b1;
                        r_cnt_ref <= '0;
                        r_cnt_str <= '0;
                        r_state   <= COUNT;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                COUNT: begin
                    r_cnt_ref <= sat_inc(r_cnt_ref, w_rise_ref);
                    r_cnt_str <= sat_inc(r_cnt_str, w_rise_str);
                    if (r_tmr == '0) begin
                        r_rosc_en <= 1'b0;
                        r_state   <= DONE;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                DONE: begin
                    r_res_ref  <= r_cnt_ref;
                    r_res_str  <= r_cnt_str;
                    r_res_diff <= w_diff;
                    r_res_ovf  <= (r_cnt_ref == '1) || (r_cnt_str == '1);
                    r_done     <= 1'b1;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ROSC_EN = r_rosc_en;
    assign bus.BUSY    = r_busy;
    assign bus.DONE    = r_done;
    assign bus.CNT_REF = r_res_ref;
    assign bus.CNT_STR = r_res_str;
    assign bus.DIFF    = r_res_diff;
    assign bus.OVF     = r_res_ovf;
endmodule

// File: tb/tb_odometer_meas_ctrl.sv
// Bench for odometer_meas_ctrl: a 16-bit and a 4-bit counter instance share
// one stimulus; a timeline model predicts every output every cycle.
module tb_odometer_meas_ctrl;
    localparam int SETTLE = 8;
    localparam int SYNC   = 2;
    localparam int MAXC   = 20000;
    localparam int MAX_A  = 65535;
    localparam int MAX_B  = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] win;
    logic        osc_ref;
    logic        osc_str;

    always #5 clk = ~clk;

    odometer_meas_ctrl_if #(.CNT_W(16), .WIN_W(16)) ifA ();
    odometer_meas_ctrl_if #(.CNT_W(4),  .WIN_W(16)) ifB ();

    assign ifA.START = start;   assign ifB.START = start;
    assign ifA.WIN_LEN = win;   assign ifB.WIN_LEN = win;
    assign ifA.OSC_REF_IN = osc_ref; assign ifB.OSC_REF_IN = osc_ref;
    assign ifA.OSC_STR_IN = osc_str; assign ifB.OSC_STR_IN = osc_str;

    odometer_meas_ctrl #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(SETTLE), .SYNC_STAGES(SYNC)) uA (
        .CLK(clk), .RST(rst), .bus(ifA.slave));
    odometer_meas_ctrl #(.CNT_W(4), .WIN_W(16), .SETTLE_CYC(SETTLE), .SYNC_STAGES(SYNC)) uB (
        .CLK(clk), .RST(rst), .bus(ifB.slave));

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act_v, input int exp_v);
        n_cmp++;
        if (act_v != exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act_v, exp_v);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // ---------------- timeline model ----------------
    // Edges are numbered from 1 after reset release. A request accepted at
    // edge t0 with window W spans L = SETTLE+W edges (L=0 for W=0); edges are
    // counted at t0+SETTLE+1 .. t0+L; results and DONE appear after t0+L+1.
    // An input rise sampled at edge k is seen by the counter at edge k+SYNC.
    int  n, t0, L, W;
    bit  act;
    bit  h_ref [0:MAXC];
    bit  h_str [0:MAXC];
    int  raw_ref, raw_str;
    int  eA_ref, eA_str, eA_diff, eB_ref, eB_str, eB_diff;
    bit  eA_ovf, eB_ovf;
    bit  e_busy, e_rosc, e_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n = 0; act = 0; t0 = 0; L = 0; W = 0;
            raw_ref = 0; raw_str = 0;
            eA_ref = 0; eA_str = 0; eA_diff = 0; eA_ovf = 0;
            eB_ref = 0; eB_str = 0; eB_diff = 0; eB_ovf = 0;
            e_busy = 0; e_rosc = 0; e_done = 0;
            for (int i = 0; i <= MAXC; i++) begin h_ref[i] = 0; h_str[i] = 0; end
        end else if (n < MAXC - 1) begin
            n = n + 1;
            h_ref[n] = osc_ref;
            h_str[n] = osc_str;
            if ((!act || n > t0 + L + 1) && start) begin
                act = 1; t0 = n; W = int'(win);
                L = (W == 0) ? 0 : SETTLE + W;
                raw_ref = 0; raw_str = 0;
            end
            if (act && W != 0 && n >= t0 + SETTLE + 1 && n <= t0 + L && n - SYNC - 1 >= 0) begin
                if (h_ref[n-SYNC] && !h_ref[n-SYNC-1]) raw_ref++;
                if (h_str[n-SYNC] && !h_str[n-SYNC-1]) raw_str++;
            end
            if (act && n == t0 + L + 1) begin
                eA_ref = sat(raw_ref, MAX_A); eA_str = sat(raw_str, MAX_A);
                eB_ref = sat(raw_ref, MAX_B); eB_str = sat(raw_str, MAX_B);
                eA_diff = eA_ref - eA_str;   eB_diff = eB_ref - eB_str;
                eA_ovf = (raw_ref >= MAX_A) || (raw_str >= MAX_A);
                eB_ovf = (raw_ref >= MAX_B) || (raw_str >= MAX_B);
            end
            e_busy = act && n >= t0 && n <= t0 + L + 1;
            e_rosc = act && W != 0 && n >= t0 && n <= t0 + L - 1;
            e_done = act && n == t0 + L + 1;
        end
    end

    // Per-cycle comparison, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("A_BUSY", int'(ifA.BUSY), int'(e_busy));
            chk("A_ROSC_EN", int'(ifA.ROSC_EN), int'(e_rosc));
            chk("A_DONE", int'(ifA.DONE), int'(e_done));
            chk("A_CNT_REF", int'(ifA.CNT_REF), eA_ref);
            chk("A_CNT_STR", int'(ifA.CNT_STR), eA_str);
            chk("A_DIFF", int'(ifA.DIFF), eA_diff);
            chk("A_OVF", int'(ifA.OVF), int'(eA_ovf));
            chk("B_BUSY", int'(ifB.BUSY), int'(e_busy));
            chk("B_ROSC_EN", int'(ifB.ROSC_EN), int'(e_rosc));
            chk("B_DONE", int'(ifB.DONE), int'(e_done));
            chk("B_CNT_REF", int'(ifB.CNT_REF), eB_ref);
            chk("B_CNT_STR", int'(ifB.CNT_STR), eB_str);
            chk("B_DIFF", int'(ifB.DIFF), eB_diff);
            chk("B_OVF", int'(ifB.OVF), int'(eB_ovf));
        end
    end

    // ---------------- oscillator returns ----------------
    bit osc_rand = 0;
    int p_ref = 4, p_str = 5, ph = 0;

    always @(negedge clk) begin
        ph++;
        if (osc_rand) begin
            osc_ref = ($urandom_range(0, 1) == 1);
            osc_str = ($urandom_range(0, 2) == 0);
        end else begin
            osc_ref = (ph % p_ref) < (p_ref / 2);
            osc_str = (ph % p_str) < (p_str / 2);
        end
    end

    // One request; returns negedges from the START drive to DONE observed
    task automatic run_meas(input int w, input int intr_at, output int lat, output bit saw_rosc);
        @(negedge clk);
        start = 1'b1; win = w[15:0]; lat = 0; saw_rosc = 0;
        while (lat < 2000) begin
            @(negedge clk);
            lat++;
            start = (lat == intr_at);
            if (lat == intr_at) win = 16'd5;
            if (ifA.ROSC_EN) saw_rosc = 1;
            if (ifA.DONE) break;
        end
        start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int lat;
    bit saw_rosc, saw_done;

    initial begin
        rst = 1'b1; start = 1'b0; win = '0; osc_ref = 0; osc_str = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ROSC_EN", int'(ifA.ROSC_EN), 0);
        chk("rst_BUSY", int'(ifA.BUSY), 0);
        chk("rst_DONE", int'(ifA.DONE), 0);
        chk("rst_CNT_REF", int'(ifA.CNT_REF), 0);
        repeat (4) @(negedge clk);

        // Basic: REF period 4, STR period 5, 100-cycle window
        p_ref = 4; p_str = 5;
        run_meas(100, 0, lat, saw_rosc);
        chk("basic_latency", lat, 110);
        chk("basic_CNT_REF", int'(ifA.CNT_REF), 25);
        chk("basic_CNT_STR", int'(ifA.CNT_STR), 20);
        chk("basic_DIFF", int'(ifA.DIFF), 5);
        chk("basic_OVF", int'(ifA.OVF), 0);
        chk("basic_B_OVF", int'(ifB.OVF), 1);
        repeat (3) @(negedge clk);

        // Negative difference
        p_ref = 5; p_str = 4;
        run_meas(100, 0, lat, saw_rosc);
        chk("neg_DIFF", int'(ifA.DIFF), -5);
        chk("neg_DIFF_bits", int'(ifA.DIFF) & 32'h1FFFF, 32'h1FFFB);
        chk("neg_OVF", int'(ifA.OVF), 0);
        repeat (3) @(negedge clk);

        // Saturation of the 4-bit instance
        p_ref = 2; p_str = 10;
        run_meas(100, 0, lat, saw_rosc);
        chk("sat_B_CNT_REF", int'(ifB.CNT_REF), 15);
        chk("sat_B_CNT_STR", int'(ifB.CNT_STR), 10);
        chk("sat_B_DIFF", int'(ifB.DIFF), 5);
        chk("sat_B_OVF", int'(ifB.OVF), 1);
        chk("sat_A_CNT_REF", int'(ifA.CNT_REF), 50);
        repeat (3) @(negedge clk);

        // Zero window
        run_meas(0, 0, lat, saw_rosc);
        chk("zero_latency", lat, 2);
        chk("zero_saw_ROSC_EN", int'(saw_rosc), 0);
        chk("zero_CNT_REF", int'(ifA.CNT_REF), 0);
        chk("zero_CNT_STR", int'(ifA.CNT_STR), 0);
        repeat (3) @(negedge clk);

        // START while busy, with a different window, is ignored
        p_ref = 4; p_str = 5;
        run_meas(100, 50, lat, saw_rosc);
        chk("busy_latency", lat, 110);
        chk("busy_CNT_REF", int'(ifA.CNT_REF), 25);
        chk("busy_CNT_STR", int'(ifA.CNT_STR), 20);
        repeat (3) @(negedge clk);

        // Reset in the middle of the counting window
        @(negedge clk); start = 1'b1; win = 16'd100;
        @(negedge clk); start = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ROSC_EN", int'(ifA.ROSC_EN), 0);
        chk("midrst_BUSY", int'(ifA.BUSY), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("midrst_CNT_REF", int'(ifA.CNT_REF), 0);
        chk("midrst_CNT_STR", int'(ifA.CNT_STR), 0);
        saw_done = 0;
        repeat (150) begin
            @(negedge clk);
            if (ifA.DONE) saw_done = 1;
        end
        chk("midrst_no_DONE", int'(saw_done), 0);

        // Randomized requests, windows and oscillator activity
        osc_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 9) == 0);
            win   = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
        end
        start = 1'b0;
        repeat (80) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
